// File: rtl/divider_nbit.sv
// -----------------------------------------------------------------------------
// divider_nbit
//   Sequential restoring divider that produces one quotient bit per clock.
//   Operands are captured on the start edge, so they may change while the
//   operation runs. In signed mode the divider works on magnitudes and fixes
//   the signs afterwards, which gives truncating (round toward zero) division.
//   A result or error stays presented until GO is released.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//   SIGNED  1'b0 = unsigned, 1'b1 = two's-complement
//
// Ports
//   clk        in   rising-edge system clock
//   rst        in   synchronous, active-high reset
//   GO         in   start request, level sampled in IDLE
//   dividend   in   X operand
//   divisor    in   Y operand
//   done       out  result or error valid (level)
//   error      out  divide-by-zero
//   ovf        out  signed overflow (MIN / -1); always 0 when unsigned
//   quotient   out  registered quotient
//   remainder  out  registered remainder
//   CS         out  current state code (IDLE=0 LOAD=1 ITER=2 FIX=3 DONE=4 ERR=5)
// -----------------------------------------------------------------------------
module divider_nbit #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             GO,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic             error,
  output logic             ovf,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [2:0]       CS
);

  // Counter must be able to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL1_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  // Two's-complement negation.
  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    neg_f = (~v) + ONE_W;
  endfunction

  // Magnitude of an operand. MIN maps onto 2^(WIDTH-1), which still fits
  // because the datapath treats the magnitude as unsigned.
  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
    if (SIGNED && v[WIDTH-1]) begin
      mag_f = neg_f(v);
    end else begin
      mag_f = v;
    end
  endfunction

  state_e           state_q;
  logic [WIDTH-1:0] dvd_q;      // captured dividend
  logic [WIDTH-1:0] dvs_q;      // captured divisor
  logic [WIDTH-1:0] r_q;        // partial remainder
  logic [WIDTH-1:0] x_q;        // dividend bits shifting out / quotient bits shifting in
  logic [WIDTH-1:0] y_q;        // divisor magnitude
  logic [CW-1:0]    cnt_q;      // quotient bits still to produce
  logic             qneg_q;     // quotient must be negated
  logic             rneg_q;     // remainder must be negated
  logic             done_q;
  logic             error_q;
  logic             ovf_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  // One restoring step. The shifted remainder needs WIDTH+1 bits: it can
  // reach 2*Y-1, which overflows WIDTH bits when Y is large.
  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] r_next_d;
  logic [WIDTH-1:0] x_next_d;
  logic             ovf_case_s;

  // Shift-compare-subtract for the ITER state.
  always_comb begin
    r_shift_s = {r_q, x_q[WIDTH-1]};
    diff_s    = r_shift_s - {1'b0, y_q};
    // r_shift < 2*Y, so the difference lies in [-Y, Y) and its top bit is a
    // reliable sign: clear means the subtraction is kept.
    ge_s      = ~diff_s[WIDTH];
    if (ge_s) begin
      r_next_d = diff_s[WIDTH-1:0];
      x_next_d = {x_q[WIDTH-2:0], 1'b1};
    end else begin
      r_next_d = r_shift_s[WIDTH-1:0];
      x_next_d = {x_q[WIDTH-2:0], 1'b0};
    end
  end

  // MIN / -1 is the only signed quotient that does not fit in WIDTH bits.
  always_comb begin
    if (SIGNED && (dvd_q == MIN_W) && (dvs_q == ALL1_W)) begin
      ovf_case_s = 1'b1;
    end else begin
      ovf_case_s = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= ZERO_W;
      dvs_q   <= ZERO_W;
      r_q     <= ZERO_W;
      x_q     <= ZERO_W;
      y_q     <= ZERO_W;
      cnt_q   <= {CW{1'b0}};
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= ZERO_W;
      rem_q   <= ZERO_W;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (GO) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            if (divisor == ZERO_W) begin
              // Divide-by-zero is reported straight away; no iterations.
              state_q <= S_ERR;
              done_q  <= 1'b1;
              error_q <= 1'b1;
              ovf_q   <= 1'b0;
              quot_q  <= ZERO_W;
              rem_q   <= ZERO_W;
            end else begin
              state_q <= S_LOAD;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_LOAD: begin
          r_q     <= ZERO_W;
          x_q     <= mag_f(dvd_q);
          y_q     <= mag_f(dvs_q);
          qneg_q  <= SIGNED & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          rneg_q  <= SIGNED & dvd_q[WIDTH-1];
          cnt_q   <= CNT_INIT;
          state_q <= S_ITER;
        end

        S_ITER: begin
          r_q   <= r_next_d;
          x_q   <= x_next_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_ITER;
          end
        end

        S_FIX: begin
          if (ovf_case_s) begin
            quot_q <= MIN_W;
            rem_q  <= ZERO_W;
            ovf_q  <= 1'b1;
          end else begin
            quot_q <= qneg_q ? neg_f(x_q) : x_q;
            rem_q  <= rneg_q ? neg_f(r_q) : r_q;
            ovf_q  <= 1'b0;
          end
          done_q  <= 1'b1;
          error_q <= 1'b0;
          state_q <= S_DONE;
        end

        // DONE and ERR hold until GO drops, so a held GO never restarts.
        S_DONE, S_ERR: begin
          if (!GO) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            ovf_q   <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end

        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          error_q <= 1'b0;
          ovf_q   <= 1'b0;
        end
      endcase
    end
  end

  assign done      = done_q;
  assign error     = error_q;
  assign ovf       = ovf_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign CS        = state_q;

endmodule
